uart_tx_fifo_drain: RTL
=======================

Name: uart_tx_fifo_drain

Overview:
UART transmitter that is the read-side consumer of the shared show-ahead FIFO. It pops bytes from the FIFO's read port and serialises each one as an 8N1 frame (8N2 optional) on a single TX line. It sits between the memory-mapped UART TX FIFO, whose write side is driven by the CPU store path, and the board TX pin.

Parameters:
CLKS_PER_BIT, 32'd868, i_clk cycles per UART bit; legal range >= 2 (868 = 100 MHz / 115200).
STOP_BITS, 32'd1, number of stop bits; legal values are 1 or 2.
WD, 32'd8, FIFO data width; only bits [7:0] are transmitted; WD must be >= 8.

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous, active-high reset
i_enable  input  1  allows a new frame to start; a frame already in flight always completes
i_fifo_empty  input  1  FIFO empty flag
i_fifo_data  input  WD  FIFO head word (show-ahead: valid whenever i_fifo_empty=0)
o_fifo_read_en  output  1  one-cycle pop strobe to the FIFO
o_tx  output  1  serial line; idle high
o_busy  output  1  high while a frame is in flight (state != IDLE)

Behaviour:
- One clock, i_clk. Reset is synchronous, active-high, on i_rst.
- Reset values: state=IDLE, o_tx=1, o_fifo_read_en=0, o_busy=0, baud counter=0, bit index=0, shift register=0.
- All outputs are registered.
- States are IDLE, START, DATA, STOP.
- IDLE:
  - When i_enable && !i_fifo_empty is sampled at edge N: latch i_fifo_data[7:0] into the shift register, drive o_fifo_read_en=1 for cycle N+1 only, move to START.
  - o_tx goes 0 from cycle N+1.
- START: o_tx=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
- DATA:
  - Transmit LSB first; each bit is held CLKS_PER_BIT cycles.
  - After bit 7, move to STOP.
  - Bit index is 3 bits and does not wrap within a frame.
- STOP:
  - o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the last STOP cycle, if i_enable && !i_fifo_empty: pop and latch as in IDLE, then go directly to START. Back-to-back frames have zero idle gap.
  - Otherwise go to IDLE.
- Frame length is exactly (9+STOP_BITS)*CLKS_PER_BIT cycles measured from the first low cycle of o_tx.
- Pop count rule: exactly one o_fifo_read_en pulse per frame. Never pop while i_fifo_empty=1. Never assert o_fifo_read_en on two consecutive cycles.
- Baud counter runs 0..CLKS_PER_BIT-1 and clears on every state or bit change. Its width is $clog2(CLKS_PER_BIT).
- i_enable low mid-frame: the current frame completes and no new pop occurs.
- i_fifo_empty rising mid-frame: no effect, because the data is already latched.
- i_rst mid-frame: next cycle o_tx=1, state=IDLE, o_fifo_read_en=0. The partial byte is lost and is not re-popped.
- i_rst high in the same cycle as a pop condition: reset wins and no pop is issued.
- i_fifo_data bits [WD-1:8] are ignored.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, STOP)
  - UART_DATA_BITS=8
  - the default CLKS_PER_BIT constant
- One sub-module, uart_baud_counter(CLKS_PER_BIT):
  - inputs: i_clk, i_rst, i_clear
  - output: o_tick, high on the last cycle of a bit period
- The FSM, shift register and pop logic stay in uart_tx_fifo_drain.

Test Plan:
- Reset held 3 cycles with i_fifo_empty=0 and i_enable=1 -> o_tx=1, o_fifo_read_en=0, o_busy=0 throughout reset.
- CLKS_PER_BIT=4, FIFO holds 0xA5, i_enable=1 -> exactly one pop; o_tx runs 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; 40 cycles total; o_busy high for those 40 cycles.
- FIFO holds 0x55 then 0x0F -> two pops exactly 40 cycles apart; the start bit of the second frame immediately follows the stop bit of the first; no idle cycle between frames.
- i_fifo_empty=1 for 200 cycles, or i_fifo_empty=0 with i_enable=0 -> zero pops, o_tx constantly 1, o_busy=0.
- i_rst pulsed during data bit 3 of 0xFF, then FIFO left empty -> o_tx=1 the cycle after reset; no further pops; o_busy=0.
- STOP_BITS=2, CLKS_PER_BIT=4, byte 0x00 -> o_tx low for 36 cycles then high for 8; frame length 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared types and constants for the UART TX FIFO drain.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 32'd868;

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ---------------------------------------------------------------------------
// uart_baud_counter : counts 0..CLKS_PER_BIT-1, ticks on the last bit cycle.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_drain : pops a show-ahead FIFO and serialises bytes as 8N1/8N2.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 32'd1,
  parameter int unsigned WD           = 32'd8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic          i_fifo_empty,
  input  logic [WD-1:0] i_fifo_data,
  output logic          o_fifo_read_en,
  output logic          o_tx,
  output logic          o_busy
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic                      tx_q, tx_d;
  logic                      rd_en_q, rd_en_d;
  logic                      busy_q, busy_d;

  logic w_tick;
  logic w_clear;
  logic w_pop_ok;
  logic w_unused_data;

  assign w_pop_ok      = i_enable && !i_fifo_empty;
  assign w_unused_data = ^i_fifo_data;

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    rd_en_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (w_pop_ok) begin
          state_d = START;
          shift_d = i_fifo_data[UART_DATA_BITS-1:0];
          rd_en_d = 1'b1;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            // Chain straight into the next start bit so frames have no gap.
            if (w_pop_ok) begin
              state_d = START;
              shift_d = i_fifo_data[UART_DATA_BITS-1:0];
              rd_en_d = 1'b1;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d  = (state_d != IDLE);
    w_clear = (state_q == IDLE) || (state_d != state_q) || (bit_idx_d != bit_idx_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
    end
  end

  assign o_fifo_read_en = rd_en_q;
  assign o_tx           = tx_q;
  assign o_busy         = busy_q;

endmodule

`default_nettype wire
